// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// States, grant encoding and starve counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } arb_state_t;

  localparam int STARVE_W = 4;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants won while fetch was waiting.
// at_max tells the arbiter to force the next fetch grant.
module arb_starve_ctr
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  input  logic [STARVE_W-1:0] max,
  output logic                at_max
);

  logic [STARVE_W-1:0] cnt;

  assign at_max = (cnt == max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM requesters onto one memory port.
// Optional MEM_PORT_ARB_PERF_EN adds perf counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_forced,
  output logic [31:0]       perf_busy
`endif
);

  arb_state_t state, state_nx;
  arb_grant_t gnt;
  logic       gnt_vld;
  logic       if_v, d_v;
  logic       at_max;
  logic       st_inc, st_clr;

  // A requester whose done is high this cycle was already served.
  assign if_v = if_req & ~if_done;
  assign d_v  = d_req & ~d_done;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

  assign st_inc = gnt_vld & (gnt == GNT_D) & if_req;
  assign st_clr = gnt_vld & (gnt == GNT_IF);

  arb_starve_ctr u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (st_inc),
    .clr    (st_clr),
    .max    (STARVE_W'(MAX_STARVE)),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_vld)
          state_nx = (gnt == GNT_IF) ? BUSY_IF : BUSY_D;
      end
      BUSY_IF,
      BUSY_D: begin
        if (mem_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt     = GNT_D;
    gnt_vld = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        if_v & (~d_v | at_max): begin
          gnt     = GNT_IF;
          gnt_vld = 1'b1;
        end
        d_v & ~(if_v & at_max): begin
          gnt     = GNT_D;
          gnt_vld = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld && gnt == GNT_IF) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (gnt_vld) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        BUSY_IF: begin
          if (mem_done) begin
            mem_req  <= 1'b0;
            if_done  <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_PORT_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflict <= '0;
      perf_forced   <= '0;
      perf_busy     <= '0;
    end else begin
      if (state == IDLE && if_req && d_req)
        perf_conflict <= perf_conflict + 1'b1;
      if (st_clr && d_v)
        perf_forced <= perf_forced + 1'b1;
      if (state != IDLE)
        perf_busy <= perf_busy + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand
// sequences and randomized traffic against a model.
module tb_mem_port_arbiter;

  localparam logic [63:0] K = 64'h5A5A_0000_0000_1111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic [63:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic        stall_if;
  logic        stall_mem;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_forced;
  logic [31:0] perf_busy;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf_conflict (perf_conflict),
    .perf_forced   (perf_forced),
    .perf_busy     (perf_busy)
`endif
  );

  int nvec = 0;
  int nbad = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Bench memory: unwritten words read as addr ^ K.
  logic [63:0] st [logic [63:0]];
  bit mem_auto = 1'b1;
  int fix_lat = 1;
  bit mact = 1'b0;
  int mcnt = 0;

  function automatic logic [63:0] rd(logic [63:0] a);
    if (st.exists(a)) return st[a];
    return a ^ K;
  endfunction

  task automatic mem_update();
    if (mem_done) begin
      mem_done  = 1'b0;
      mact      = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end else if (mem_auto) begin
      if (mem_req && !mact) begin
        mact = 1'b1;
        mcnt = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 8));
      end
      if (mact) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_done = 1'b1;
          if (mem_we) begin
            mem_rdata = {$urandom, $urandom};
            st[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = rd(mem_addr);
          end
        end
      end
    end
  endtask

  // Transaction-level reference: who should own the port and what
  // each requester should see, derived from the arbitration rules.
  bit          p_mreq, p_ifd, p_dd;
  int          starve;
  bit          pend_d, pwe;
  logic [63:0] pa, pw, pexp;
  logic [63:0] m_ifr, m_dr;
  int          ngrant, ndone;
  bit          ev_grant, ev_gnt_d;

  task automatic model_reset();
    p_mreq = 0; p_ifd = 0; p_dd = 0;
    starve = 0; pend_d = 0; pwe = 0;
    pa = '0; pw = '0; pexp = '0;
    m_ifr = '0; m_dr = '0;
    ngrant = 0; ndone = 0;
  endtask

  task automatic model_check();
    bit ie, de, gi, gd;
    ie = if_req && !p_ifd;
    de = d_req && !p_dd;
    if (!p_mreq) begin
      gi = ie && (!de || starve == 4);
      gd = de && !gi;
      chkb("idle_if_done", if_done, 1'b0);
      chkb("idle_d_done", d_done, 1'b0);
      chkb("grant_req", mem_req, gi || gd);
      if (gi || gd) begin
        pend_d = gd;
        pa     = gd ? d_addr : if_addr;
        pwe    = gd && d_we;
        pw     = d_wdata;
        pexp   = rd(pa);
        chk("grant_addr", mem_addr, pa);
        chkb("grant_we", mem_we, pwe);
        if (gd) chk("grant_wdata", mem_wdata, pw);
        if (gd) begin
          if (if_req && starve < 4) starve++;
        end else begin
          starve = 0;
        end
        ngrant++;
        ev_grant = 1'b1;
        ev_gnt_d = gd;
      end
    end else if (mem_done) begin
      chkb("done_req_drop", mem_req, 1'b0);
      chkb("done_if", if_done, !pend_d);
      chkb("done_d", d_done, pend_d);
      if (!pend_d) m_ifr = pexp;
      else if (!pwe) m_dr = pexp;
      ndone++;
    end else begin
      chkb("busy_req", mem_req, 1'b1);
      chk("busy_addr", mem_addr, pa);
      chkb("busy_we", mem_we, pwe);
      if (pend_d) chk("busy_wdata", mem_wdata, pw);
      chkb("busy_if_done", if_done, 1'b0);
      chkb("busy_d_done", d_done, 1'b0);
    end
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
    chkb("stall_if", stall_if, if_req && !if_done);
    chkb("stall_mem", stall_mem, d_req && !d_done);
    p_mreq = mem_req;
    p_ifd  = if_done;
    p_dd   = d_done;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_check();
    mem_update();
  endtask

  task automatic do_reset();
    if_req = 0; d_req = 0; d_we = 0;
    reset = 1'b0;
    #1;
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_if_rdata", if_rdata, 64'h0);
    chk("rst_d_rdata", d_rdata, 64'h0);
    chkb("rst_if_done", if_done, 1'b0);
    chkb("rst_d_done", d_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    mem_done = 1'b0;
    mact = 1'b0;
    reset = 1'b1;
  endtask

  typedef struct {
    bit          ir;
    logic [63:0] ia;
    bit          dr;
    bit          dwe;
    logic [63:0] da;
    logic [63:0] dwd;
    int          lat;
    bit          edf;
    logic [63:0] eifr;
    logic [63:0] edr;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit got_first, first_d, got, fin;
    int ng;
    logic [7:0] seq;

    vt[0] = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0,
              1, 1'b0, 64'h00A00093, 64'h0};
    vt[1] = '{1'b1, 64'h44, 1'b1, 1'b0, 64'h200, 64'h0,
              2, 1'b1, 64'h44 ^ K, 64'h200 ^ K};
    vt[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h300, 64'hDEADBEEF,
              3, 1'b1, 64'h44 ^ K, 64'h200 ^ K};
    vt[3] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h300, 64'h0,
              1, 1'b1, 64'h44 ^ K, 64'hDEADBEEF};
    vt[4] = '{1'b1, 64'h48, 1'b1, 1'b1, 64'h308, 64'h1234,
              4, 1'b1, 64'h48 ^ K, 64'hDEADBEEF};
    vt[5] = '{1'b1, 64'h308, 1'b0, 1'b0, 64'h0, 64'h0,
              8, 1'b0, 64'h1234, 64'hDEADBEEF};
    st[64'h40] = 64'h00A00093;

    do_reset();

    for (int i = 0; i < 6; i++) begin
      if_req = vt[i].ir;  if_addr = vt[i].ia;
      d_req = vt[i].dr;   d_we = vt[i].dwe;
      d_addr = vt[i].da;  d_wdata = vt[i].dwd;
      fix_lat = vt[i].lat;
      got_first = 0; first_d = 0;
      for (int c = 0; c < 60 && (if_req || d_req); c++) begin
        ev_grant = 0;
        tick();
        if (c == 0) begin
          chkb("vec_req_rise", mem_req, 1'b1);
          chk("vec_first_addr", mem_addr,
              vt[i].edf ? vt[i].da : vt[i].ia);
        end
        if (ev_grant && !got_first) begin
          got_first = 1;
          first_d = ev_gnt_d;
        end
        if (if_done) if_req = 0;
        if (d_done) d_req = 0;
      end
      chkb("vec_timeout", if_req || d_req, 1'b0);
      chkb("vec_first_d", first_d, vt[i].edf);
      chk("vec_if_rdata", if_rdata, vt[i].eifr);
      chk("vec_d_rdata", d_rdata, vt[i].edr);
      tick();
    end

    // Drop the request while the transaction is in flight.
    fix_lat = 3;
    d_req = 1; d_we = 0; d_addr = 64'h500;
    tick();
    d_req = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (d_done) got = 1;
    end
    chkb("drop_done", got, 1'b1);
    chk("drop_rdata", d_rdata, 64'h500 ^ K);
    tick();

    // Fetch held except in data-done cycles: 4 data wins, then fetch.
    do_reset();
    fix_lat = 1;
    d_req = 1; d_we = 0; d_addr = 64'h1000;
    if_req = 1; if_addr = 64'h80;
    seq = '0; ng = 0; fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      ev_grant = 0;
      tick();
      if (ev_grant) begin
        seq = {seq[6:0], ev_gnt_d};
        ng++;
      end
      if (if_done) begin
        fin = 1; if_req = 0; d_req = 0;
      end else if (d_done) begin
        d_addr = d_addr + 64'h8;
        if_req = 0;
      end else begin
        if_req = 1;
      end
    end
    chkb("starve_fin", fin, 1'b1);
    chk("starve_ngrants", 64'(ng), 64'd5);
    chk("starve_seq", 64'(seq), 64'h1E);
    chk("starve_if_rdata", if_rdata, 64'h80 ^ K);
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_forced", 64'(perf_forced), 64'd1);
    chk("perf_busy", 64'(perf_busy), 64'd5);
`endif
    tick();

    // Reset mid-transaction, then a late mem_done in IDLE.
    do_reset();
    mem_auto = 0;
    d_req = 1; d_we = 0; d_addr = 64'h600;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chkb("midrst_req", mem_req, 1'b0);
    chkb("midrst_d_done", d_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chkb("midrst_hold_done", d_done, 1'b0);
    d_req = 0;
    model_reset();
    reset = 1'b1;
    mem_done = 1'b1;
    mem_rdata = 64'hBAD0BAD0BAD0BAD0;
    tick();
    tick();
    chkb("late_done_req", mem_req, 1'b0);
    chk("late_done_rdata", d_rdata, 64'h0);
    mem_auto = 1;

    // Randomized traffic with variable memory latency.
    do_reset();
    fix_lat = 0;
    for (int c = 0; c < 8000 && ndone < 200; c++) begin
      tick();
      if (if_done) begin
        if ($urandom_range(0, 1) == 1)
          if_addr = 64'($urandom_range(0, 31)) << 3;
        else
          if_req = 0;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1;
        if_addr = 64'($urandom_range(0, 31)) << 3;
      end
      if (d_done) begin
        if ($urandom_range(0, 1) == 1) begin
          d_addr = 64'($urandom_range(0, 31)) << 3;
          d_we = 1'($urandom_range(0, 1));
          d_wdata = {$urandom, $urandom};
        end else begin
          d_req = 0;
        end
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_addr = 64'($urandom_range(0, 31)) << 3;
        d_we = 1'($urandom_range(0, 1));
        d_wdata = {$urandom, $urandom};
      end
    end
    chkb("rand_txns", ndone >= 200, 1'b1);
    if_req = 0;
    d_req = 0;
    for (int c = 0; c < 20; c++) tick();
    chk("rand_balance", 64'(ndone), 64'(ngrant));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage).
- Fixed priority with data first, plus a starvation guard that forces a fetch grant after repeated losses.
- Registers the winning request and holds it on the memory port until the memory completes.
- Returns a one-cycle done pulse with read data, and drives stall signals back to the pipeline hazard logic.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory port
- DATA_W, 64, data width
- MAX_STARVE, 4, consecutive data-won conflicts after which fetch is forced to win (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid with if_done
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_done
- d_done  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, held until mem_done
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_done
- mem_done  in  1  memory completion, one cycle, latency ≥1 cycle after mem_req rises
- stall_if  out  1  freeze the PC and IF/ID register
- stall_mem  out  1  freeze the pipeline at the MEM stage

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is asynchronous and active-low.
  - On reset the state is IDLE, starve_cnt is 0, and every registered output is 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done.
  - Reset mid-transaction abandons the transaction. mem_req drops asynchronously and no done pulse is issued.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - d_req only → grant data.
  - if_req only → grant fetch.
  - Both → grant data, unless starve_cnt == MAX_STARVE, in which case grant fetch.
  - On grant, capture the address, we and wdata into the memory-port registers and set mem_req on the next edge. State becomes BUSY_D or BUSY_IF.
  - A fetch grant always has mem_we = 0.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - Input changes, including new requests, are ignored.
  - On the edge where mem_done = 1:
    - clear mem_req;
    - pulse x_done for exactly one cycle;
    - capture mem_rdata into x_rdata (loads and fetches only; d_rdata is unchanged on a store);
    - return to IDLE.
- Latency and throughput:
  - Minimum request-to-done latency is mem latency + 2 cycles.
  - One dead IDLE cycle separates back-to-back transactions.
- Done timing: the done pulse coincides with the first IDLE cycle. A requester that still holds req during that cycle has already been served. Requesters must deassert req or change address in the done cycle, and IDLE ignores a requester whose done is high that cycle.
- Requester drops req while BUSY: the transaction still completes and the done pulse is still issued.
- Starvation counter:
  - Increments (saturating at MAX_STARVE) when data is granted while if_req = 1.
  - Clears to 0 on any fetch grant.
  - Otherwise holds.
- Stall outputs (combinational): stall_if = if_req & ~if_done; stall_mem = d_req & ~d_done.
- Spurious mem_done: mem_done in IDLE is ignored.

Optional Feature:
- Macro: MEM_PORT_ARB_PERF_EN.
- Defined: adds three 32-bit outputs, each wrapping at 2^32 and cleared by reset:
  - perf_conflict: increments on cycles in IDLE with both requests present;
  - perf_forced: increments on starvation-forced fetch grants;
  - perf_busy: increments on cycles in BUSY_IF or BUSY_D.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, BUSY_IF, BUSY_D};
  - localparam STARVE_W = 4;
  - typedef enum logic {GNT_IF, GNT_D} arb_grant_t.
- One natural sub-module, arb_starve_ctr: the saturating starve counter, with inputs inc, clr and max and output at_max.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x40, memory latency 1, mem_rdata=0x00A00093 → mem_req rises 1 cycle later with mem_addr=0x40; if_done pulses once with if_rdata=0x00A00093; stall_if is high until the pulse.
- Simultaneous requests: d_req (load 0x200) and if_req (0x44) in the same cycle → data is served first; fetch is granted in the IDLE cycle after d_done; starve_cnt goes 1 → 0.
- Starvation: d_req held with new addresses after each done, and if_req held → 4 data grants, then the 5th grant goes to fetch (MAX_STARVE=4); with the perf macro, perf_forced=1.
- Store: d_we=1, d_addr=0x300, d_wdata=0xDEADBEEF → mem_we=1 with the data stable until mem_done; d_done pulses; d_rdata keeps its previous value.
- Reset mid-BUSY_D with latency 5: reset asserted at cycle 2 → mem_req drops immediately; no d_done; state is IDLE after release; a late mem_done is ignored.
- Variable latency 1..8 cycles randomized over 200 transactions → exactly one done pulse per grant, and mem_addr and mem_we never change while mem_req=1.
